// File: rtl/spike_gen_scheduler_pkg.sv
// Shared types for the spike generator scheduler.
// Contents: default widths, the per-generator entry layout and FSM state codes.
package spike_gen_scheduler_pkg;

   localparam int unsigned NGENS_DEF   = 8;
   localparam int unsigned NPERIOD_DEF = 16;
   localparam int unsigned NTAG_DEF    = 11;

   // Per-generator state entry at the default widths (software-visible layout)
   typedef struct packed {
      logic [NPERIOD_DEF-1:0] period;
      logic [NPERIOD_DEF-1:0] ticks;
      logic [NTAG_DEF-1:0]    tag;
   } gen_entry_t;

   // FSM state codes
   localparam int unsigned STATE_W = 2;
   localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
   localparam logic [STATE_W-1:0] ST_READ = 2'd1;
   localparam logic [STATE_W-1:0] ST_EVAL = 2'd2;
   localparam logic [STATE_W-1:0] ST_EMIT = 2'd3;

endpackage

// File: rtl/spike_gen_state_mem.sv
// Simple dual-port RAM holding per-generator {period, ticks, tag}.
// Ports: clk; we_i/waddr_i/wdata_i write port; raddr_i/rdata_o registered
// read port with one cycle of latency. Contents are never reset.
module spike_gen_state_mem #(
   parameter int unsigned AW = 8,
   parameter int unsigned DW = 43
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o
);

   localparam int unsigned DEPTH = 1 << AW;

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] rdata_q;

   // Write port and registered read port, block-RAM style
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/spike_gen_scheduler.sv
// Time-driven spike generator scheduler.
// On each time_unit pulse, sweeps generators 0..gens_used, counting down each
// enabled generator's ticks and emitting its tag on expiry.
// Ports: clk, reset (sync, active-high); time_unit pulse; gens_used/gens_en
// sweep configuration; prog_* programming channel (prog_a combinational ack);
// out_tag/out_v/out_a emit channel; overrun sticky dropped-time-unit flag.
module spike_gen_scheduler
   import spike_gen_scheduler_pkg::*;
#(
   parameter int unsigned Ngens   = NGENS_DEF,
   parameter int unsigned Nperiod = NPERIOD_DEF,
   parameter int unsigned Ntag    = NTAG_DEF
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    time_unit,
   input  logic [Ngens-1:0]        gens_used,
   input  logic [(2**Ngens)-1:0]   gens_en,
   input  logic [Ngens-1:0]        prog_gen_idx,
   input  logic [Nperiod-1:0]      prog_period,
   input  logic [Nperiod-1:0]      prog_ticks,
   input  logic [Ntag-1:0]         prog_tag,
   input  logic                    prog_v,
   output logic                    prog_a,
   output logic [Ntag-1:0]         out_tag,
   output logic                    out_v,
   input  logic                    out_a,
   output logic                    overrun
);

   localparam int unsigned EW = 2 * Nperiod + Ntag;

   typedef struct packed {
      logic [Nperiod-1:0] period;
      logic [Nperiod-1:0] ticks;
      logic [Ntag-1:0]    tag;
   } entry_t;

   logic [STATE_W-1:0] state_q, state_d;
   logic [Ngens-1:0]   idx_q, idx_d;
   logic               pending_q, pending_d;
   logic               overrun_q, overrun_d;
   logic               out_v_q, out_v_d;
   logic [Ntag-1:0]    out_tag_q, out_tag_d;

   logic               we_c;
   logic [Ngens-1:0]   waddr_c;
   entry_t             wr_c;
   entry_t             rd_c;
   logic [EW-1:0]      rdata_c;
   logic               prog_a_c;
   logic               advance_c;
   logic               pend_clr_c;

   spike_gen_state_mem #(
      .AW (Ngens),
      .DW (EW)
   ) u_mem (
      .clk     (clk),
      .we_i    (we_c & ~reset),
      .waddr_i (waddr_c),
      .wdata_i (wr_c),
      .raddr_i (idx_q),
      .rdata_o (rdata_c)
   );

   assign rd_c = entry_t'(rdata_c);

   // State and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         idx_q     <= '0;
         pending_q <= 1'b0;
         overrun_q <= 1'b0;
         out_v_q   <= 1'b0;
         out_tag_q <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         pending_q <= pending_d;
         overrun_q <= overrun_d;
         out_v_q   <= out_v_d;
         out_tag_q <= out_tag_d;
      end
   end

   // Next-state, memory write and pending/overrun logic
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      pending_d  = pending_q;
      overrun_d  = overrun_q;
      out_v_d    = out_v_q;
      out_tag_d  = out_tag_q;
      we_c       = 1'b0;
      waddr_c    = idx_q;
      wr_c       = rd_c;
      prog_a_c   = 1'b0;
      advance_c  = 1'b0;
      pend_clr_c = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // Programming has priority over starting a sweep
            if (prog_v) begin
               prog_a_c    = 1'b1;
               we_c        = 1'b1;
               waddr_c     = prog_gen_idx;
               wr_c.period = prog_period;
               wr_c.ticks  = prog_ticks;
               wr_c.tag    = prog_tag;
            end else if (pending_q) begin
               pend_clr_c = 1'b1;
               pending_d  = 1'b0;
               idx_d      = '0;
               state_d    = ST_READ;
            end
         end
         ST_READ: begin
            state_d = ST_EVAL;
         end
         ST_EVAL: begin
            advance_c = 1'b1;
            if (gens_en[idx_q] && (rd_c.period != '0)) begin
               we_c = 1'b1;
               if (rd_c.ticks == '0) begin
                  wr_c.ticks = rd_c.period - Nperiod'(1);
                  out_tag_d  = rd_c.tag;
                  out_v_d    = 1'b1;
                  advance_c  = 1'b0;
                  state_d    = ST_EMIT;
               end else begin
                  wr_c.ticks = rd_c.ticks - Nperiod'(1);
               end
            end
         end
         ST_EMIT: begin
            if (out_a) begin
               out_v_d   = 1'b0;
               advance_c = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // gens_used is sampled here so a mid-sweep change applies immediately
      if (advance_c) begin
         if (idx_q < gens_used) begin
            idx_d   = idx_q + Ngens'(1);
            state_d = ST_READ;
         end else begin
            state_d = ST_IDLE;
         end
      end

      // A pulse landing on the cycle pending is consumed re-arms it without loss
      if (time_unit) begin
         pending_d = 1'b1;
         if (pending_q && !pend_clr_c) begin
            overrun_d = 1'b1;
         end
      end
   end

   assign prog_a  = prog_a_c & ~reset;
   assign out_v   = out_v_q;
   assign out_tag = out_tag_q;
   assign overrun = overrun_q;

endmodule
